// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared register-file indexing constants and helpers
package regfile_writeback_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // One-hot mask for a register index; x0 never appears in any mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        m[0]   = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// rtl/regfile_writeback_fifo.sv - pointer/count FIFO buffering load results
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push offered while full is dropped even if a pop frees a slot this cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write-port arbiter with RAW scoreboard
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int MEM_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_rd,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [4:0]           mem_rd,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [WORD_SIZE-1:0] wb_data
);

    localparam int ENTRY_W = REG_IDX_W + WORD_SIZE;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [ENTRY_W-1:0]   fifo_head;
    logic                 sel_valid;
    logic [4:0]           sel_rd;
    logic [WORD_SIZE-1:0] sel_data;
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  set_mask;
    logic [NUM_REGS-1:0]  clr_mask;

    assign mem_ready = !fifo_full;
    // Loads drain only in cycles the ALU leaves the write port free.
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (MEM_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_valid),
        .push_data ({mem_rd, mem_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Priority select: ALU first, else the oldest buffered load.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = REG_ZERO;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_head[ENTRY_W-1 -: REG_IDX_W];
            sel_data  = fifo_head[WORD_SIZE-1:0];
        end
    end

    // Output register; results for x0 are consumed without enabling a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= REG_ZERO;
            wb_data <= '0;
        end else begin
            wb_en <= sel_valid && (sel_rd != REG_ZERO);
            if (sel_valid) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    // Set on issue, clear on the edge the register file commits the write.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid) begin
            set_mask = reg_onehot(issue_rd);
        end
        if (wb_en) begin
            clr_mask = reg_onehot(wb_rd);
        end
    end

    // Pending-write scoreboard; a same-edge set of the rd being cleared wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_rs1 = (rs1 != REG_ZERO) && busy[rs1];
    assign busy_rs2 = (rs2 != REG_ZERO) && busy[rs2];

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - cycle-table bench for regfile_writeback
module tb_regfile_writeback;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_rdy;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    logic [31:0] pend;

    regfile_writeback #(.WORD_SIZE(32), .MEM_FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    // Protocol guard on the stimulus: no issue to an rd whose write is still pending.
    always @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (issue_valid && issue_rd != 5'd0 && pend[issue_rd] && !(wb_en && wb_rd == issue_rd))
                $error("FAIL waw_protocol rd=%0d", issue_rd);
            pend <= (pend & ~((wb_en && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0))
                  | ((issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0);
        end
    end

    function automatic vec_t T(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic e_en, input logic [4:0] e_rd, input logic [31:0] e_data,
                               input logic e_rdy, input logic e_b1, input logic e_b2);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
        v.e_en = e_en; v.e_rd = e_rd; v.e_data = e_data;
        v.e_rdy = e_rdy; v.e_b1 = e_b1; v.e_b2 = e_b2;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check this cycle's outputs, then advance past the edge.
    task automatic run_row(input vec_t v, input int row);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
        issue_valid = v.iv; issue_rd = v.ird; rs1 = v.s1; rs2 = v.s2;
        @(negedge clk);
        chk("wb_en", row, 32'(wb_en), 32'(v.e_en));
        if (v.e_en) begin
            chk("wb_rd", row, 32'(wb_rd), 32'(v.e_rd));
            chk("wb_data", row, wb_data, v.e_data);
        end
        chk("mem_ready", row, 32'(mem_ready), 32'(v.e_rdy));
        chk("busy_rs1", row, 32'(busy_rs1), 32'(v.e_b1));
        chk("busy_rs2", row, 32'(busy_rs2), 32'(v.e_b2));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 5'd5; rs2 = 5'd9;

        // Reset state
        @(negedge clk);
        chk("rst_wb_en", 0, 32'(wb_en), 32'd0);
        chk("rst_wb_rd", 0, 32'(wb_rd), 32'd0);
        chk("rst_wb_data", 0, wb_data, 32'd0);
        chk("rst_mem_ready", 0, 32'(mem_ready), 32'd1);
        chk("rst_busy_rs1", 0, 32'(busy_rs1), 32'd0);
        chk("rst_busy_rs2", 0, 32'(busy_rs2), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU alone
        tbl.push_back(T(1,7,32'hDEADBEEF, 0,0,0, 0,0, 0,0, 0,0,0,           1,0,0));
        tbl.push_back(T(0,0,0,            0,0,0, 0,0, 0,0, 1,7,32'hDEADBEEF, 1,0,0));
        tbl.push_back(T(0,0,0,            0,0,0, 0,0, 0,0, 0,0,0,           1,0,0));
        // Contention: load waits behind three ALU writes
        tbl.push_back(T(0,0,0,     1,3,32'h11, 0,0, 0,0, 0,0,0,     1,0,0));
        tbl.push_back(T(1,1,32'hA1, 0,0,0,     0,0, 0,0, 0,0,0,     1,0,0));
        tbl.push_back(T(1,2,32'hA2, 0,0,0,     0,0, 0,0, 1,1,32'hA1, 1,0,0));
        tbl.push_back(T(1,4,32'hA3, 0,0,0,     0,0, 0,0, 1,2,32'hA2, 1,0,0));
        tbl.push_back(T(0,0,0,      0,0,0,     0,0, 0,0, 1,4,32'hA3, 1,0,0));
        tbl.push_back(T(0,0,0,      0,0,0,     0,0, 0,0, 1,3,32'h11, 1,0,0));
        tbl.push_back(T(0,0,0,      0,0,0,     0,0, 0,0, 0,0,0,      1,0,0));
        // Full FIFO under ALU pressure, then in-order drain
        tbl.push_back(T(1,10,32'h100, 1,11,32'hB0, 0,0, 0,0, 0,0,0,         1,0,0));
        tbl.push_back(T(1,10,32'h101, 1,12,32'hB1, 0,0, 0,0, 1,10,32'h100, 1,0,0));
        tbl.push_back(T(1,10,32'h102, 1,13,32'hB2, 0,0, 0,0, 1,10,32'h101, 1,0,0));
        tbl.push_back(T(1,10,32'h103, 1,14,32'hB3, 0,0, 0,0, 1,10,32'h102, 1,0,0));
        tbl.push_back(T(1,10,32'h104, 1,15,32'hB4, 0,0, 0,0, 1,10,32'h103, 0,0,0));
        tbl.push_back(T(0,0,0,        1,16,32'hB5, 0,0, 0,0, 1,10,32'h104, 0,0,0));
        tbl.push_back(T(0,0,0,        0,0,0,       0,0, 0,0, 1,11,32'hB0,  1,0,0));
        tbl.push_back(T(0,0,0,        0,0,0,       0,0, 0,0, 1,12,32'hB1,  1,0,0));
        tbl.push_back(T(0,0,0,        0,0,0,       0,0, 0,0, 1,13,32'hB2,  1,0,0));
        tbl.push_back(T(0,0,0,        0,0,0,       0,0, 0,0, 1,14,32'hB3,  1,0,0));
        tbl.push_back(T(0,0,0,        0,0,0,       0,0, 0,0, 0,0,0,        1,0,0));
        // Scoreboard set, clear, and same-edge re-issue
        tbl.push_back(T(0,0,0,      0,0,0, 1,9, 0,9, 0,0,0,      1,0,0));
        tbl.push_back(T(0,0,0,      0,0,0, 0,0, 0,9, 0,0,0,      1,0,1));
        tbl.push_back(T(1,9,32'h99, 0,0,0, 0,0, 0,9, 0,0,0,      1,0,1));
        tbl.push_back(T(0,0,0,      0,0,0, 1,9, 0,9, 1,9,32'h99, 1,0,1));
        tbl.push_back(T(1,9,32'h9A, 0,0,0, 0,0, 0,9, 0,0,0,      1,0,1));
        tbl.push_back(T(0,0,0,      0,0,0, 0,0, 9,9, 1,9,32'h9A, 1,1,1));
        tbl.push_back(T(0,0,0,      0,0,0, 0,0, 9,9, 0,0,0,      1,0,0));
        // x0 results are consumed silently
        tbl.push_back(T(1,0,32'h5, 0,0,0,      1,0, 0,0, 0,0,0,      1,0,0));
        tbl.push_back(T(0,0,0,     1,0,32'h6,  0,0, 0,0, 0,0,0,      1,0,0));
        tbl.push_back(T(0,0,0,     1,8,32'h88, 0,0, 0,0, 0,0,0,      1,0,0));
        tbl.push_back(T(0,0,0,     0,0,0,      0,0, 0,0, 0,0,0,      1,0,0));
        tbl.push_back(T(0,0,0,     0,0,0,      0,0, 0,0, 1,8,32'h88, 1,0,0));
        tbl.push_back(T(0,0,0,     0,0,0,      0,0, 0,0, 0,0,0,      1,0,0));
        // Back-to-back loads: push and pop in the same cycle
        tbl.push_back(T(0,0,0, 1,24,32'hC0, 0,0, 0,0, 0,0,0,       1,0,0));
        tbl.push_back(T(0,0,0, 1,25,32'hC1, 0,0, 0,0, 0,0,0,       1,0,0));
        tbl.push_back(T(0,0,0, 1,26,32'hC2, 0,0, 0,0, 1,24,32'hC0, 1,0,0));
        tbl.push_back(T(0,0,0, 0,0,0,       0,0, 0,0, 1,25,32'hC1, 1,0,0));
        tbl.push_back(T(0,0,0, 0,0,0,       0,0, 0,0, 1,26,32'hC2, 1,0,0));
        tbl.push_back(T(0,0,0, 0,0,0,       0,0, 0,0, 0,0,0,       1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], i + 1);
        end

        // Reset mid-traffic: three loads buffered, busy[5] set
        run_row(T(1,20,32'd1, 1,21,32'hD1, 1,5, 0,0, 0,0,0,      1,0,0), 101);
        run_row(T(1,20,32'd2, 1,22,32'hD2, 0,0, 0,0, 1,20,32'd1, 1,0,0), 102);
        run_row(T(1,20,32'd3, 1,23,32'hD3, 0,0, 5,0, 1,20,32'd2, 1,1,0), 103);
        rst = 1'b1;
        run_row(T(1,20,32'd4, 0,0,0,       0,0, 5,0, 1,20,32'd3, 1,1,0), 104);
        rst = 1'b0;
        run_row(T(0,0,0,      0,0,0,       0,0, 5,0, 0,0,0,      1,0,0), 105);
        chk("post_rst_wb_rd", 105, 32'(wb_rd), 32'd0);
        chk("post_rst_wb_data", 105, wb_data, 32'd0);
        run_row(T(0,0,0,      0,0,0,       0,0, 5,0, 0,0,0,      1,0,0), 106);
        run_row(T(0,0,0,      0,0,0,       0,0, 5,0, 0,0,0,      1,0,0), 107);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
